// File: rtl/invader_fleet.sv
// invader_fleet: one-row invader formation that marches, descends, takes bullet hits and flags cleared/landed (FLEET_SPEEDUP_EN shortens the step period as kills mount)
module invader_fleet #(
  parameter int COLS = 20,
  parameter int LAND_LINE = 14,
  parameter int STEP_TICKS = 8,
  parameter logic [COLS-1:0] INIT_PATTERN = 20'b00101010101010101010
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            Enable,
  input  logic            startPulse,
  input  logic [4:0]      BulletX,
  input  logic [3:0]      BulletY,
  input  logic            BulletActive,
  output logic [COLS-1:0] invArray,
  output logic [3:0]      invLine,
  output logic            hit,
  output logic            waveCleared,
  output logic            landed
);
  typedef enum logic [1:0] {IDLE, MARCH, CLEARED, LANDED} state_t;
  state_t state_q;
  logic [COLS-1:0] mask_q, hit_bit, post;
  logic [3:0] line_q, line_inc;
  logic [7:0] tick_q, period;
  logic dir_q, hit_q, wc_q, ld_q, hit_det, step, at_edge, load;
  assign load = state_q != MARCH && startPulse;
  assign hit_bit = {{(COLS-1){1'b0}}, 1'b1} << BulletX;
  assign hit_det = state_q == MARCH && BulletActive && BulletY == line_q && |(mask_q & hit_bit);
  assign post = hit_det ? mask_q & ~hit_bit : mask_q;
  assign step = Enable && tick_q >= period - 8'd1;
  assign at_edge = dir_q ? post[0] : post[COLS-1];
  assign line_inc = line_q + 4'd1;
`ifdef FLEET_SPEEDUP_EN
  logic [3:0] kills_q;
  // period shrinks by one Enable for every two kills, never below one
  always_comb period = STEP_TICKS > int'(kills_q >> 1) + 1 ? 8'(STEP_TICKS - int'(kills_q >> 1)) : 8'd1;
  // saturating kill counter, restarted with each wave
  always_ff @(posedge clk)
    if (reset || clear || load) kills_q <= '0;
    else if (hit_det && kills_q != 4'hF) kills_q <= kills_q + 4'd1;
`else
  assign period = 8'(STEP_TICKS);
`endif
  // wave FSM: load, collision removal, marching/descent and end-of-wave detection
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= IDLE;
      mask_q  <= '0;
      line_q  <= '0;
      dir_q   <= 1'b0;
      tick_q  <= '0;
      hit_q   <= 1'b0;
      wc_q    <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      hit_q <= hit_det;
      if (load) begin
        state_q <= MARCH;
        mask_q  <= INIT_PATTERN;
        line_q  <= '0;
        dir_q   <= 1'b0;
        tick_q  <= '0;
        wc_q    <= 1'b0;
        ld_q    <= 1'b0;
      end else if (state_q == MARCH) begin
        mask_q <= post;
        if (post == '0) begin
          state_q <= CLEARED;
          wc_q    <= 1'b1;
        end else if (step) begin
          tick_q <= '0;
          if (at_edge) begin
            line_q <= line_inc;
            dir_q  <= ~dir_q;
            if (line_inc == 4'(LAND_LINE)) begin
              state_q <= LANDED;
              ld_q    <= 1'b1;
            end
          end else mask_q <= dir_q ? post >> 1 : post << 1;
        end else if (Enable) tick_q <= tick_q + 8'd1;
      end
    end
  end
  assign invArray = mask_q;
  assign invLine = line_q;
  assign hit = hit_q;
  assign waveCleared = wc_q;
  assign landed = ld_q;
endmodule

// File: tb/tb_invader_fleet.sv
// tb_invader_fleet: randomized scoreboard bench against a behavioural fleet model
module tb_invader_fleet;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, Enable = 1'b0, startPulse = 1'b0, BulletActive = 1'b0;
  logic [4:0] BulletX = '0;
  logic [3:0] BulletY = '0;
  logic [19:0] invArray;
  logic [3:0] invLine;
  logic hit, waveCleared, landed;
  int checks = 0, failures = 0;
  logic [26:0] exp_q[$];
  logic [26:0] exp_v;
  localparam bit [19:0] INIT = 20'h2AAAA;
  int m_phase, m_line, m_ticks, m_kills;
  bit [19:0] m_mask;
  bit m_right, m_hit, m_wc, m_ld;

  always #5 clk = ~clk;

  invader_fleet dut (
    .clk(clk), .reset(reset), .clear(clear), .Enable(Enable), .startPulse(startPulse),
    .BulletX(BulletX), .BulletY(BulletY), .BulletActive(BulletActive),
    .invArray(invArray), .invLine(invLine), .hit(hit), .waveCleared(waveCleared), .landed(landed)
  );

  // phases: 0 idle, 1 marching, 2 cleared, 3 landed
  task automatic model_cycle(bit rst, bit clr, bit en, bit sp, bit ba, logic [4:0] bx, logic [3:0] by);
    int p, hi, lo;
    m_hit = 0;
    if (rst || clr) begin
      m_phase = 0; m_mask = '0; m_line = 0; m_right = 1; m_ticks = 0; m_kills = 0; m_wc = 0; m_ld = 0;
      return;
    end
    if (m_phase != 1) begin
      if (sp) begin
        m_phase = 1; m_mask = INIT; m_line = 0; m_right = 1; m_ticks = 0; m_kills = 0; m_wc = 0; m_ld = 0;
      end
      return;
    end
    p = 8;
`ifdef FLEET_SPEEDUP_EN
    p = 8 - m_kills / 2;
    if (p < 1) p = 1;
`endif
    if (ba && int'(by) == m_line && int'(bx) < 20 && m_mask[bx]) begin
      m_mask[bx] = 1'b0;
      m_hit = 1;
      if (m_kills < 15) m_kills++;
    end
    if (m_mask == 0) begin
      m_phase = 2; m_wc = 1;
      return;
    end
    if (!en) return;
    m_ticks++;
    if (m_ticks < p) return;
    m_ticks = 0;
    hi = -1; lo = 20;
    for (int c = 0; c < 20; c++) if (m_mask[c]) begin
      if (c > hi) hi = c;
      if (c < lo) lo = c;
    end
    if (m_right ? hi == 19 : lo == 0) begin
      m_line++;
      m_right = !m_right;
      if (m_line == 14) begin m_phase = 3; m_ld = 1; end
    end else m_mask = m_right ? m_mask << 1 : m_mask >> 1;
  endtask

  task automatic drive(bit rst, bit clr, bit en, bit sp, bit ba, logic [4:0] bx, logic [3:0] by);
    @(negedge clk);
    reset = rst; clear = clr; Enable = en; startPulse = sp; BulletActive = ba; BulletX = bx; BulletY = by;
    model_cycle(rst, clr, en, sp, ba, bx, by);
    exp_q.push_back({m_mask, 4'(m_line), m_hit, m_wc, m_ld});
  endtask

  task automatic spot(string name, logic [19:0] got, logic [19:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({invArray, invLine, hit, waveCleared, landed} !== exp_v) begin
        failures++;
        $display("FAIL outputs t=%0t got arr=%h line=%0d hit=%b wc=%b ld=%b want arr=%h line=%0d hit=%b wc=%b ld=%b",
                 $time, invArray, invLine, hit, waveCleared, landed,
                 exp_v[26:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    int mode;
    int live[$];
    bit rst, clr, en, sp, ba;
    logic [4:0] bx;
    logic [3:0] by;
    repeat (2) drive(1, 0, 0, 0, 0, 5'd0, 4'd0);
    @(posedge clk); #3;
    spot("reset_arr", invArray, 20'h0);
    spot("reset_flags", {17'd0, hit, waveCleared, landed}, 20'h0);
    drive(0, 0, 0, 1, 0, 5'd0, 4'd0);
    @(posedge clk); #3;
    spot("start_arr", invArray, 20'h2AAAA);
    spot("start_line", invLine, 20'h0);
    repeat (5) drive(0, 0, 0, 0, 1, 5'd1, 4'd0);
    @(posedge clk); #3;
    spot("hit_bit1", invArray, 20'h2AAA8);
    repeat (2) drive(0, 0, 0, 0, 1, 5'd0, 4'd0);
    drive(0, 1, 0, 0, 0, 5'd0, 4'd0);
    drive(0, 0, 0, 1, 0, 5'd0, 4'd0);
    repeat (8) drive(0, 0, 1, 0, 0, 5'd0, 4'd0);
    @(posedge clk); #3;
    spot("first_step", invArray, 20'h55554);
    spot("first_step_line", invLine, 20'h0);
    for (int b = 0; b < 24; b++) begin
      mode = b % 3;
      repeat (400) begin
        rst = mode != 2 && $urandom_range(0, 499) == 0;
        clr = mode != 2 && $urandom_range(0, 299) == 0;
        en = mode == 2 ? 1'b1 : 1'($urandom_range(0, 1));
        sp = $urandom_range(0, 29) == 0;
        ba = 0; bx = 5'($urandom_range(0, 31)); by = 4'($urandom_range(0, 15));
        if (mode == 0) begin
          ba = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) by = 4'(m_line);
        end else if (mode == 1) begin
          ba = 1;
          by = 4'(m_line);
          live.delete();
          for (int c = 0; c < 20; c++) if (m_mask[c]) live.push_back(c);
          if (live.size() > 0 && $urandom_range(0, 4) != 0) bx = 5'(live[$urandom_range(0, live.size() - 1)]);
        end
        drive(rst, clr, en, sp, ba, bx, by);
      end
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
